// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_reader
// Purpose  : Receive side of a multiplexed, time-scanned 7-segment display
//            bus. Each digit's segment pattern is synchronized, debounced and
//            decoded back to a hex nibble. Once every digit has been captured,
//            the full frame is presented on a valid/ready output.
// Ports    : clk          system clock
//            reset        asynchronous, active-low reset
//            seg[6:0]     segment bus {a,b,c,d,e,f,g}, a = bit 6
//            dig_sel      one-hot digit enable, bit k = digit k
//            frame_ready  consumer accepts the presented frame
//            frame_valid  frame_hex/frame_err hold a complete frame
//            frame_hex    decoded digits, digit k at [4k+3:4k]
//            frame_err    bit k = digit k held an illegal pattern
//            overrun      sticky, a completed frame was dropped
// Options  : SEG_ACTIVE_LOW_EN - invert seg and dig_sel at the pins
//            (common-anode display); internal behaviour is unchanged.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_reader #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_sel,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [4*NDIG-1:0] frame_hex,
  output logic [NDIG-1:0]   frame_err,
  output logic              overrun
);

  localparam int BW = 7 + NDIG;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  // The counter saturates one above the sample point so the sample value is
  // present for exactly one cycle per stable period.
  localparam logic [CW-1:0] STABLE_HIT = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_SAT = CW'(STABLE_CYCLES);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  logic [BW-1:0]     bus_in;
  logic [BW-1:0]     sync1;
  logic [BW-1:0]     sync2;
  logic [BW-1:0]     prev;
  logic [CW-1:0]     stable_cnt;
  logic [6:0]        seg_s;
  logic [NDIG-1:0]   sel_s;
  logic              onehot;
  logic              sample;
  logic [4:0]        dec;
  logic [4*NDIG-1:0] slot_hex;
  logic [NDIG-1:0]   slot_err;
  logic [NDIG-1:0]   seen;
  logic [4*NDIG-1:0] slot_hex_nxt;
  logic [NDIG-1:0]   slot_err_nxt;
  logic [NDIG-1:0]   seen_nxt;
  logic              frame_done;
  logic              xfer;
  state_t            state;

`ifdef SEG_ACTIVE_LOW_EN
  assign bus_in = ~{seg, dig_sel};
`else
  assign bus_in = {seg, dig_sel};
`endif

  // Two-flop synchronizer plus a one-cycle history for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      stable_cnt <= '0;
    end else begin
      sync1 <= bus_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (sync2 != prev) begin
        stable_cnt <= '0;
      end else if (stable_cnt != STABLE_SAT) begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

  assign seg_s  = sync2[BW-1:NDIG];
  assign sel_s  = sync2[NDIG-1:0];
  assign onehot = (sel_s != '0) &&
                  ((sel_s & (sel_s - {{(NDIG-1){1'b0}}, 1'b1})) == '0);
  assign sample = onehot && (stable_cnt == STABLE_HIT);

  // Returns {illegal, nibble}; illegal patterns decode to nibble 0.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
      7'b1110111: r = 5'h0A;
      7'b0011111: r = 5'h0B;
      7'b1001110: r = 5'h0C;
      7'b0111101: r = 5'h0D;
      7'b1001111: r = 5'h0E;
      7'b1000111: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  assign dec = decode_seg(seg_s);

  // Slot contents including this cycle's sample, so a completing frame can
  // be loaded straight from here without losing its last digit.
  always_comb begin
    slot_hex_nxt = slot_hex;
    slot_err_nxt = slot_err;
    seen_nxt     = seen;
    if (sample) begin
      for (int k = 0; k < NDIG; k++) begin
        if (sel_s[k]) begin
          slot_hex_nxt[4*k +: 4] = dec[3:0];
          slot_err_nxt[k]        = dec[4];
        end
      end
      seen_nxt = seen | sel_s;
    end
  end

  assign frame_done = sample && (seen_nxt == '1);
  assign xfer       = frame_valid && frame_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_hex    <= '0;
      slot_err    <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      frame_hex   <= '0;
      frame_err   <= '0;
      overrun     <= 1'b0;
      state       <= COLLECT;
    end else begin
      // Collection runs regardless of state; a completed frame always
      // restarts the seen mask, whether it is presented or dropped.
      slot_hex <= slot_hex_nxt;
      slot_err <= slot_err_nxt;
      seen     <= frame_done ? '0 : seen_nxt;
      case (state)
        COLLECT: begin
          if (frame_done) begin
            frame_hex   <= slot_hex_nxt;
            frame_err   <= slot_err_nxt;
            frame_valid <= 1'b1;
            state       <= PRESENT;
          end
        end
        PRESENT: begin
          if (frame_done && xfer) begin
            frame_hex <= slot_hex_nxt;
            frame_err <= slot_err_nxt;
          end else if (frame_done) begin
            overrun <= 1'b1;
          end else if (xfer) begin
            frame_valid <= 1'b0;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
`default_nettype wire
